// File: rtl/uart_model_pkg.sv
// Shared types and sizing helpers for the bench-side UART transmitter model.
package uart_model_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Bit counter covers up to 8 payload bits or 2 stop bits.
  localparam int BIT_CNT_W = 3;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered occupancy and a sticky overflow flag.
// A write at full is still accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             push, pop;

  assign pop     = rd_en && (cnt != '0);
  assign push    = wr_en && ((cnt != FULL_CNT) || pop);
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_model.sv
// Bench-side UART transmitter: byte FIFO feeding a start/data/stop serialiser.
// Frames run back to back when the FIFO has data on the last stop cycle.
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        uart_tx_en,
  input  logic                        wr_en,
  input  logic [PAYLOAD_BITS-1:0]     wr_data,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        uart_tx_busy,
  output logic                        uart_txd
);

  import uart_model_pkg::*;

  localparam int CPB    = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int BAUD_W = cnt_w(CPB);
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_t                state_q, state_d;
  logic [BAUD_W-1:0]        baud_q, baud_d;
  logic [BIT_CNT_W-1:0]     bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0]  shift_q, shift_d;
  logic                     txd_q, txd_d;
  logic                     pop;
  logic [PAYLOAD_BITS-1:0]  head;
  logic                     bit_end;

  uart_tx_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  assign bit_end      = (baud_q == BAUD_LAST);
  assign uart_tx_busy = (state_q != IDLE);
  assign uart_txd     = txd_q;

  // State, counters, shifter and line register; reset forces the line idle at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic; txd_d is the line value for the coming bit period.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (uart_tx_en && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          txd_d   = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            state_d = STOP;
            txd_d   = 1'b1;
            bit_d   = '0;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (uart_tx_en && !fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
              state_d = START;
              txd_d   = 1'b0;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_model.sv
// Scoreboard bench: writes push expected bytes, line monitors decode frames
// from both transmitters and compare against the queues.
module tb_uart_tx_model;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en, wr_en, en2, wr_en2;
  logic [7:0] wr_data, wr_data2;
  logic       full, empty, ovf, busy, txd;
  logic       full2, empty2, ovf2, busy2, txd2;
  logic [4:0] count, count2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] exp_q0[$], exp_q1[$];
  int         starts0[$], starts1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_model #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .uart_tx_en(en), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(full), .fifo_empty(empty), .fifo_count(count), .overflow(ovf),
    .uart_tx_busy(busy), .uart_txd(txd));

  uart_tx_model #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .resetn(resetn), .uart_tx_en(en2), .wr_en(wr_en2), .wr_data(wr_data2),
    .fifo_full(full2), .fifo_empty(empty2), .fifo_count(count2), .overflow(ovf2),
    .uart_tx_busy(busy2), .uart_txd(txd2));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel != 0) ? txd2 : txd;
  endfunction

  // Line receiver: samples bit centres, aborts silently if reset hits mid-frame.
  task automatic rx(input int sel, input int nstop);
    logic [7:0] b;
    bit ab, ferr;
    int t0, idx;
    int last;
    last = (8 + nstop) * CPB + CPB / 2;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && line_of(sel) === 1'b0) begin
        t0 = cyc; b = '0; ab = 0; ferr = 0;
        for (int k = 1; k <= last && !ab; k++) begin
          @(negedge clk);
          if (resetn !== 1'b1) ab = 1;
          else if (k % CPB == CPB / 2) begin
            idx = k / CPB;
            if (idx == 0)      ferr = ferr | (line_of(sel) !== 1'b0);
            else if (idx <= 8) b[idx-1] = line_of(sel);
            else               ferr = ferr | (line_of(sel) !== 1'b1);
          end
        end
        if (!ab) begin
          if (sel != 0) starts1.push_back(t0); else starts0.push_back(t0);
          chk($sformatf("rx%0d framing", sel), int'(ferr), 0);
          if ((sel != 0 ? exp_q1.size() : exp_q0.size()) == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rx%0d unexpected byte: got 0x%0h expected none", sel, b);
          end else if (sel != 0) chk("rx1 byte", int'(b), int'(exp_q1.pop_front()));
          else                   chk("rx0 byte", int'(b), int'(exp_q0.pop_front()));
        end
      end
    end
  endtask

  initial rx(0, 1);
  initial rx(1, 2);

  task automatic wr(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel != 0) begin wr_en2 = 1'b1; wr_data2 = b; end
    else          begin wr_en  = 1'b1; wr_data  = b; end
  endtask

  task automatic wr_done(input int sel);
    @(negedge clk);
    if (sel != 0) wr_en2 = 1'b0; else wr_en = 1'b0;
  endtask

  // Wait for the expected queue to empty and the transmitter to go idle.
  task automatic drain(input int sel, input int budget, input string nm);
    int n = 0;
    while (((sel != 0 ? exp_q1.size() : exp_q0.size()) != 0 ||
            (sel != 0 ? busy2 : busy)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " drained in budget"}, int'(n < budget), 1);
  endtask

  initial begin
    int n, s, lows;
    resetn = 1'b0; en = 1'b0; wr_en = 1'b0; wr_data = '0;
    en2 = 1'b0; wr_en2 = 1'b0; wr_data2 = '0;
    repeat (3) @(negedge clk);
    chk("reset txd", txd, 1);
    chk("reset busy", busy, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset count", count, 0);
    chk("reset overflow", ovf, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x41: start one cycle after the write edge, 100 busy cycles.
    en = 1'b1;
    exp_q0.push_back(8'h41);
    wr(0, 8'h41); wr_done(0);
    chk("t1 txd before start", txd, 1);
    chk("t1 count after write", count, 1);
    @(negedge clk);
    chk("t1 start bit", txd, 0);
    chk("t1 busy", busy, 1);
    chk("t1 count after pop", count, 0);
    n = 0;
    while (busy && n < 500) begin n++; @(negedge clk); end
    chk("t1 busy cycles", n, 100);
    drain(0, 300, "t1");

    // "Hi\n" back to back: no idle gap between frames.
    s = starts0.size();
    exp_q0.push_back(8'h48); exp_q0.push_back(8'h69); exp_q0.push_back(8'h0A);
    wr(0, 8'h48); wr(0, 8'h69); wr(0, 8'h0A); wr_done(0);
    drain(0, 600, "t2");
    chk("t2 frames", starts0.size() - s, 3);
    if (starts0.size() >= s + 3) begin
      chk("t2 gap 1", starts0[s+1] - starts0[s], 100);
      chk("t2 gap 2", starts0[s+2] - starts0[s+1], 100);
    end

    // Fill with transmit disabled, overflow on the 17th write, then drain.
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(0, 8'(i));
      exp_q0.push_back(8'(i));
    end
    @(negedge clk);
    chk("t3 full after 16", full, 1);
    chk("t3 count after 16", count, 16);
    chk("t3 overflow before 17th", ovf, 0);
    wr_data = 8'h10;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t3 overflow after 17th", ovf, 1);
    chk("t3 count after 17th", count, 16);
    chk("t3 full after 17th", full, 1);
    en = 1'b1;
    drain(0, 2000, "t3");
    repeat (50) @(negedge clk);
    chk("t3 overflow sticky", ovf, 1);
    chk("t3 empty at end", empty, 1);

    // Disable mid-frame: current frame completes, queued byte waits.
    exp_q0.push_back(8'h55);
    wr(0, 8'h55); wr(0, 8'hAA); wr_done(0);
    repeat (34) @(negedge clk);
    en = 1'b0;
    drain(0, 300, "t4a");
    lows = 0;
    repeat (200) begin @(negedge clk); if (!txd) lows++; end
    chk("t4 line idle while disabled", lows, 0);
    chk("t4 byte held", count, 1);
    exp_q0.push_back(8'hAA);
    en = 1'b1;
    drain(0, 300, "t4b");

    // Two stop bits: 110-cycle frames, back to back.
    s = starts1.size();
    en2 = 1'b1;
    exp_q1.push_back(8'hFF); exp_q1.push_back(8'hFF);
    wr(1, 8'hFF); wr(1, 8'hFF); wr_done(1);
    drain(1, 600, "t6");
    chk("t6 frames", starts1.size() - s, 2);
    if (starts1.size() >= s + 2)
      chk("t6 frame period", starts1[s+1] - starts1[s], 110);

    // Reset mid-frame: line idles immediately, queue discarded.
    wr(0, 8'h33); wr(0, 8'h44); wr_done(0);
    repeat (49) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("t5 async txd", txd, 1);
    chk("t5 async busy", busy, 0);
    chk("t5 async empty", empty, 1);
    chk("t5 async count", count, 0);
    chk("t5 async overflow", ovf, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    repeat (300) begin @(negedge clk); if (!txd) lows++; end
    chk("t5 nothing after reset", lows, 0);
    chk("t5 busy after reset", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_model.md
Name: uart_tx_model

Overview:
- Testbench UART transmitter that sits directly upstream of the co-sim UART receive path.
- Accepts bytes from bench/C-side tasks through a write-only FIFO and serialises them onto a single line.
- The line drives the DUT UART RX pin, or loops back to the bench receiver for self-check.
- Frame format is identical to the receiver's: start bit, PAYLOAD_BITS LSB-first, STOP_BITS stop bits, idle high, no parity.

Parameters:
- BIT_RATE, 9600, line bit rate in bits/s.
- CLK_HZ, 50_000_000, clk frequency in Hz; CYCLES_PER_BIT = CLK_HZ / BIT_RATE (integer division, must be >= 2).
- PAYLOAD_BITS, 8, data bits per frame (5..8).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- FIFO_DEPTH, 16, byte FIFO entries, power of two >= 2.

Ports:
- clk  in  1  bench clock
- resetn  in  1  asynchronous active-low reset
- uart_tx_en  in  1  permits starting new frames
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  PAYLOAD_BITS  byte to send
- fifo_full  out  1  count == FIFO_DEPTH
- fifo_empty  out  1  count == 0
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky, set when a write is dropped
- uart_tx_busy  out  1  frame in progress
- uart_txd  out  1  serial line, registered

Behaviour:
- Reset (async assert, sync release): uart_txd=1, uart_tx_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, pointers=0.
- Reset asserted mid-frame aborts immediately: uart_txd=1 with no partial-frame completion, and FIFO contents are discarded.
- FIFO write rule: wr_en is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A write at full with no same-cycle pop is dropped, sets overflow, and leaves contents unchanged.
  - overflow clears only on reset.
- Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Flags and fifo_count are registered and reflect state after the current edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd=1, busy=0. If uart_tx_en=1 and the FIFO is non-empty: pop the head into the shift register, go to START, uart_txd=0, busy=1, reset the bit counter.
  - START: hold 0 for CYCLES_PER_BIT cycles, then go to DATA and drive shift[0].
  - DATA: each bit is held CYCLES_PER_BIT cycles, shift right after each; after PAYLOAD_BITS bits go to STOP, uart_txd=1.
  - STOP: hold 1 for STOP_BITS*CYCLES_PER_BIT cycles. On the final cycle, if uart_tx_en=1 and the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE and busy=0.
- Latency: a write sampled at edge k into an empty FIFO with the FSM in IDLE produces uart_txd=0 from edge k+1. The full frame occupies (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles.
- uart_tx_en deasserted mid-frame: the current frame completes normally and no new frame starts. Bytes remain queued until it reasserts.
- The baud counter is $clog2(CYCLES_PER_BIT) bits wide and counts 0..CYCLES_PER_BIT-1; it is reloaded on every state or bit transition.

Decomposition:
- Shared package uart_model_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Function cycles_per_bit(CLK_HZ, BIT_RATE).
  - Localparam helpers for counter widths.
- One sub-module uart_tx_fifo (synchronous single-clock byte FIFO with count and overflow flag).
- FSM and shifter stay in uart_tx_model.

Test Plan (CLK_HZ=50_000_000, BIT_RATE=5_000_000, so 10 cycles/bit):
- Write 0x41 once with uart_tx_en=1 -> uart_txd sequence per 10-cycle bit is 0,1,0,0,0,0,0,1,0,1. busy is high for exactly 100 cycles; the start bit falls 1 cycle after the write.
- Loopback into the existing bench receiver; write "Hi\n" (0x48,0x69,0x0A) back-to-back -> receiver logs "Hi". No idle cycles occur between the three frames (300 cycles total).
- With uart_tx_en=0, write 17 bytes 0x00..0x10 -> fifo_full=1 after 16 writes, overflow=1 after the 17th, fifo_count=16. Then enable -> bytes 0x00..0x0F are transmitted and 0x10 is never sent.
- Deassert uart_tx_en at cycle 35 of a frame carrying 0x55 with 0xAA queued -> the 0x55 frame completes and uart_txd stays 1. Reassert -> 0xAA is sent.
- Assert resetn=0 at cycle 50 of a frame -> uart_txd=1 in the same cycle (async), fifo_empty=1, busy=0. After release nothing is transmitted.
- STOP_BITS=2: write 0xFF twice -> each frame is 110 cycles, with 20 high cycles between the last data bit and the next start bit.
